mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external memory bus between instruction fetch (IF) and the MEM stage.
//  Accepts one IF request and one MEM request, grants one at a time, and drives the bus.
//  Returns read data and per-port done pulses; raises stall requests to pipeline control.
//  Aborts any transfer whose ack never arrives, using a timeout.
// PARAMETERS
//  TIMEOUT    16  max cycles in a BUSY state waiting for bus_ack_i before abort (>=2)
//  STARVE_MAX 4   consecutive MEM grants while IF pending before IF is forced next (>=1)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset; synchronous, active-high
//  if_ce_i        in   1   IF read request (level, held until if_done_o)
//  if_addr_i      in   32  IF word address
//  if_data_o      out  32  IF read data, valid with if_done_o
//  if_done_o      out  1   1-cycle pulse: IF transfer complete
//  mem_ce_i       in   1   MEM request (level, held until mem_done_o)
//  mem_we_i       in   1   1=store, 0=load
//  mem_sel_i      in   4   byte lane select
//  mem_addr_i     in   32  MEM byte address
//  mem_data_i     in   32  store data
//  mem_data_o     out  32  load data, valid with mem_done_o
//  mem_done_o     out  1   1-cycle pulse: MEM transfer complete
//  stallreq_if_o  out  1   IF requesting and not completing this cycle
//  stallreq_mem_o out  1   MEM requesting and not completing this cycle
//  bus_err_o      out  1   1-cycle pulse on timeout abort (with the port's done pulse)
//  bus_ce_o       out  1   bus cycle active
//  bus_we_o       out  1   bus write enable
//  bus_sel_o      out  4   bus byte select
//  bus_addr_o     out  32  bus address
//  bus_data_o     out  32  bus write data
//  bus_data_i     in   32  bus read data, valid with bus_ack_i
//  bus_ack_i      in   1   bus ack; ends the current transfer
// BEHAVIOUR
//  Reset: state=IDLE; timeout and starve counters = 0. All registered outputs are 0.
//  Bus signals are 0 and stalls follow request lines combinationally (0 with no request).
//  States: IDLE, IF_BUSY, MEM_BUSY (registered FSM).
//  IDLE: if only one ce is high, grant it. If both are high, grant MEM,
//   unless starve counter == STARVE_MAX; then grant IF.
//   Grant registers the requester's addr/we/sel/data into bus regs. This is one cycle of latency.
//   bus_ce_o rises the cycle after the request is seen.
//  IF_BUSY: bus_we_o=0, bus_sel_o=4'b1111. On bus_ack_i, latch bus_data_i to if_data_o.
//   Pulse if_done_o next cycle, return to IDLE, and clear the starve counter.
//  MEM_BUSY: drive latched we/sel/addr/data. On bus_ack_i, latch bus_data_i to mem_data_o
//   (load only; store leaves mem_data_o unchanged). Pulse mem_done_o and return to IDLE.
//   If if_ce_i was high at grant, increment the starve counter, saturating at STARVE_MAX.
//  Done pulses are registered, in the IDLE cycle after ack. Min transfer = 3 cycles
//   from request to done with a same-cycle ack. IDLE never grants in the cycle a done pulses.
//   The requester drops ce on done, so the completed request is never regranted.
//  Timeout: counter runs in BUSY states and clears on entry. At TIMEOUT-1 without ack:
//   - abort to IDLE and drop bus_ce_o;
//   - pulse the port's done together with bus_err_o;
//   - leave the port's data output unchanged.
//  bus_ack_i in IDLE is ignored. A requester dropping ce mid-transfer is not supported;
//   the transfer completes and done still pulses.
//  bus_* outputs stay stable throughout a BUSY state and are 0 in IDLE.
//  stallreq_x_o = x_ce_i & ~x_done_o (combinational).
//  rst during BUSY: next cycle is IDLE, all outputs 0, and no done pulse is issued.
// TESTING
//  IF only, addr=0x100, ack 2 cycles after ce -> one bus read at 0x100,
//   if_done_o pulse with data; stallreq_if_o high until done.
//  MEM store, sel=4'b0011, data=0xDEADBEEF, ack immediate -> bus_we_o=1 with those values;
//   mem_done_o pulse 3 cycles after request; mem_data_o unchanged.
//  IF and MEM both held high, repeated MEM requests -> after STARVE_MAX(4) MEM grants,
//   IF granted; starve counter cleared.
//  No ack for TIMEOUT(16) cycles on a MEM load -> bus_ce_o drops;
//   mem_done_o and bus_err_o pulse together; mem_data_o retains its old value.
//  rst asserted in MEM_BUSY with ack in the same cycle -> IDLE;
//   no mem_done_o; all outputs 0 next cycle.
//  bus_ack_i toggled in IDLE with no requests -> no done pulses, no state change.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between instruction fetch and MEM, with starvation guard and ack timeout
module mem_bus_arbiter #(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_done_o,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o,
    output logic        bus_err_o,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);
    state_t r_state, w_next;
    logic [TW-1:0] r_tcnt;
    logic [SW-1:0] r_starve;
    logic r_if_wait, r_we, r_if_done, r_mem_done, r_err;
    logic [3:0] r_sel;
    logic [31:0] r_addr, r_wdata, r_if_data, r_mem_data;
    logic w_busy, w_ack, w_timeout, w_end, w_idle_ok, w_grant_if, w_grant_mem;
    always_comb begin
        w_busy = r_state != IDLE;
        w_ack = w_busy & bus_ack_i;
        w_timeout = w_busy & ~bus_ack_i & (r_tcnt == T_LAST);
        w_end = w_ack | w_timeout;
        w_idle_ok = (r_state == IDLE) & ~r_if_done & ~r_mem_done;
        w_grant_mem = w_idle_ok & mem_ce_i & ~(if_ce_i & (r_starve == S_MAX));
        w_grant_if = w_idle_ok & if_ce_i & ~w_grant_mem;
        w_next = w_end ? IDLE : w_grant_mem ? MEM_BUSY : w_grant_if ? IF_BUSY : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tcnt <= '0;
            r_starve <= '0;
            r_if_wait <= 1'b0;
            r_we <= 1'b0;
            r_sel <= '0;
            r_addr <= '0;
            r_wdata <= '0;
            r_if_data <= '0;
            r_mem_data <= '0;
            r_if_done <= 1'b0;
            r_mem_done <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tcnt <= w_busy ? r_tcnt + TW'(1) : '0;
            r_if_done <= w_end & (r_state == IF_BUSY);
            r_mem_done <= w_end & (r_state == MEM_BUSY);
            r_err <= w_timeout;
            if (w_grant_if) begin
                r_addr <= if_addr_i;
                r_we <= 1'b0;
                r_sel <= 4'hf;
                r_wdata <= '0;
            end
            if (w_grant_mem) begin
                r_addr <= mem_addr_i;
                r_we <= mem_we_i;
                r_sel <= mem_sel_i;
                r_wdata <= mem_data_i;
                r_if_wait <= if_ce_i;
            end
            if (w_ack & (r_state == IF_BUSY)) r_if_data <= bus_data_i;
            if (w_ack & (r_state == MEM_BUSY) & ~r_we) r_mem_data <= bus_data_i;
            if (w_end & (r_state == IF_BUSY)) r_starve <= '0;
            if (w_end & (r_state == MEM_BUSY) & r_if_wait & (r_starve != S_MAX)) r_starve <= r_starve + SW'(1);
        end
    end
    assign if_data_o = r_if_data;
    assign if_done_o = r_if_done;
    assign mem_data_o = r_mem_data;
    assign mem_done_o = r_mem_done;
    assign bus_err_o = r_err;
    assign stallreq_if_o = if_ce_i & ~r_if_done;
    assign stallreq_mem_o = mem_ce_i & ~r_mem_done;
    assign bus_ce_o = w_busy;
    assign bus_we_o = w_busy & r_we;
    assign bus_sel_o = w_busy ? r_sel : '0;
    assign bus_addr_o = w_busy ? r_addr : '0;
    assign bus_data_o = w_busy ? r_wdata : '0;
endmodule
